// File: rtl/timer_int_if.sv
// Request/acknowledge bundle between the EX/fetch stages and timer_int_ctrl.
// slave = controller side, master = pipeline side.
interface timer_int_if #(
  parameter int NUM_CH = 4,
  parameter int NUM_IO = 2,
  parameter int CNT_W  = 32,
  parameter int VEC_W  = 32
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NS    = NUM_CH + NUM_IO;

  logic             ld_en;
  logic [SEL_W-1:0] ld_sel;
  logic [CNT_W-1:0] ld_val;
  logic             ld_mode;
  logic             dis;
  logic [NUM_IO-1:0] io_irq;
  logic             int_ack;
  logic             rti;
  logic             irq_req;
  logic [VEC_W-1:0] irq_vec;
  logic [NS-1:0]    irq_src;
  logic             in_service;
  logic [NS-1:0]    pending;

  modport master (
    output ld_en, ld_sel, ld_val, ld_mode, dis, io_irq, int_ack, rti,
    input  irq_req, irq_vec, irq_src, in_service, pending
  );

  modport slave (
    input  ld_en, ld_sel, ld_val, ld_mode, dis, io_irq, int_ack, rti,
    output irq_req, irq_vec, irq_src, in_service, pending
  );
endinterface

// File: rtl/timer_int_ctrl.sv
// N-channel interval timer plus lowest-index-wins interrupt controller with a single-level in-service lock.
// Optional build macro TIMER_INT_PRESCALE_EN adds i_presc_div and an 8-bit tick prescaler.
module timer_int_ctrl #(
  parameter int               NUM_CH     = 4,
  parameter int               NUM_IO     = 2,
  parameter int               CNT_W      = 32,
  parameter int               VEC_W      = 32,
  parameter logic [VEC_W-1:0] VEC_BASE   = 'h9,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 'h4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef TIMER_INT_PRESCALE_EN
  input  logic [7:0]  i_presc_div,
`endif
  timer_int_if.slave  bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NS    = NUM_CH + NUM_IO;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt [NUM_CH];
  logic [CNT_W-1:0]   r_rld [NUM_CH];
  logic [NUM_CH-1:0]  r_en, r_mode;
  logic [NS-1:0]      r_pend, r_src;
  logic [NUM_IO-1:0]  r_io_prev;
  logic [VEC_W-1:0]   r_vec;
  logic [NUM_CH-1:0]  w_ld, w_dis, w_exp;
  logic [NS-1:0]      w_set, w_clr, w_win;
  logic [VEC_W-1:0]   w_vec;
  logic               w_tick;

`ifdef TIMER_INT_PRESCALE_EN
  logic [7:0] r_presc;
  assign w_tick = (r_presc == i_presc_div);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_presc <= 8'd0;
    else          r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
  end
`else
  assign w_tick = 1'b1;
`endif

  // load beats dis, and both suppress an expiry on the same channel
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_ld[ch]  = bus.ld_en && (bus.ld_sel == SEL_W'(ch));
      w_dis[ch] = bus.dis && (bus.ld_sel == SEL_W'(ch)) && !w_ld[ch];
      w_exp[ch] = r_en[ch] && w_tick && (r_cnt[ch] == CNT_W'(1)) && !w_ld[ch] && !w_dis[ch];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_cnt[ch] <= '0;
        r_rld[ch] <= '0;
      end
      r_en   <= '0;
      r_mode <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_ld[ch]) begin
          r_cnt[ch]  <= bus.ld_val;
          r_rld[ch]  <= bus.ld_val;
          r_en[ch]   <= (bus.ld_val != '0);
          r_mode[ch] <= bus.ld_mode;
        end else if (w_dis[ch]) begin
          r_cnt[ch] <= '0;
          r_en[ch]  <= 1'b0;
        end else if (w_exp[ch]) begin
          if (r_mode[ch]) begin
            r_cnt[ch] <= r_rld[ch];
          end else begin
            r_cnt[ch] <= '0;
            r_en[ch]  <= 1'b0;
          end
        end else if (r_en[ch] && w_tick && (r_cnt[ch] > CNT_W'(1))) begin
          r_cnt[ch] <= r_cnt[ch] - CNT_W'(1);
        end
      end
    end
  end

  // a set in the same cycle as the ack-clear keeps the bit pending
  always_comb begin
    w_set = {bus.io_irq & ~r_io_prev, w_exp};
    w_clr = {{NUM_IO{1'b0}}, w_ld | w_dis};
    if (r_state == REQ && bus.int_ack) w_clr = w_clr | r_src;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend    <= '0;
      r_io_prev <= '0;
    end else begin
      r_pend    <= (r_pend & ~w_clr) | w_set;
      r_io_prev <= bus.io_irq;
    end
  end

  always_comb begin
    w_win = '0;
    w_vec = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_win    = '0;
        w_win[i] = 1'b1;
        w_vec    = VEC_BASE + VEC_W'(i) * VEC_STRIDE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|r_pend)     w_state_nxt = REQ;
      REQ:     if (bus.int_ack) w_state_nxt = SERVICE;
      SERVICE: if (bus.rti)     w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // source/vector are captured once on leaving IDLE and frozen until rti
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec <= '0;
      r_src <= '0;
    end else if (r_state == IDLE && |r_pend) begin
      r_vec <= w_vec;
      r_src <= w_win;
    end else if (r_state == SERVICE && bus.rti) begin
      r_src <= '0;
    end
  end

  always_comb begin
    bus.irq_req    = (r_state == REQ);
    bus.in_service = (r_state == SERVICE);
    bus.irq_vec    = r_vec;
    bus.irq_src    = r_src;
    bus.pending    = r_pend;
  end
endmodule

// File: tb/tb_timer_int_ctrl.sv
// Scoreboard bench for timer_int_ctrl: an event-time reference model predicts every request,
// a negedge monitor compares requests, vectors, sources, pending and service state.
module tb_timer_int_ctrl;
  localparam int NUM_CH = 4;
  localparam int NUM_IO = 2;
  localparam int NS     = NUM_CH + NUM_IO;
  localparam int IDLE_S = 0, REQ_S = 1, SVC_S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_int_if #(.NUM_CH(NUM_CH), .NUM_IO(NUM_IO), .CNT_W(32), .VEC_W(32)) bus ();
  timer_int_ctrl #(.NUM_CH(NUM_CH), .NUM_IO(NUM_IO), .CNT_W(32), .VEC_W(32),
                   .VEC_BASE(32'h9), .VEC_STRIDE(32'h4))
    dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: channels tracked by absolute expiry time ----------------
  typedef struct { longint cyc; int idx; } exp_t;
  exp_t          sbq[$];
  longint        cyc = 0;
  bit            m_en   [NUM_CH];
  bit            m_mode [NUM_CH];
  longint        m_per  [NUM_CH];
  longint        m_next [NUM_CH];
  logic [NS-1:0] m_pend, m_old, m_set, m_clr;
  logic [NUM_IO-1:0] m_prev;
  int            m_state, m_src;
  bit            ld_c, dis_c;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) m_en[c] = 0;
      m_pend = '0; m_prev = '0; m_state = IDLE_S; m_src = 0;
      sbq.delete();
    end else begin
      cyc++;
      m_old = m_pend; m_set = '0; m_clr = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ld_c  = bus.ld_en && (int'(bus.ld_sel) == c);
        dis_c = bus.dis && (int'(bus.ld_sel) == c) && !ld_c;
        if (ld_c) begin
          m_clr[c] = 1; m_mode[c] = bus.ld_mode; m_per[c] = longint'(bus.ld_val);
          m_en[c] = (bus.ld_val != 0); m_next[c] = cyc + longint'(bus.ld_val);
        end else if (dis_c) begin
          m_clr[c] = 1; m_en[c] = 0;
        end else if (m_en[c] && cyc == m_next[c]) begin
          m_set[c] = 1;
          if (m_mode[c]) m_next[c] += m_per[c];
          else           m_en[c] = 0;
        end
      end
      for (int i = 0; i < NUM_IO; i++)
        if (bus.io_irq[i] && !m_prev[i]) m_set[NUM_CH+i] = 1;
      m_prev = bus.io_irq;
      case (m_state)
        IDLE_S: if (m_old != 0) begin
          for (int i = NS - 1; i >= 0; i--) if (m_old[i]) m_src = i;
          m_state = REQ_S;
          sbq.push_back('{cyc, m_src});
        end
        REQ_S: if (bus.int_ack) begin m_clr[m_src] = 1; m_state = SVC_S; end
        default: if (bus.rti) m_state = IDLE_S;
      endcase
      m_pend = (m_old & ~m_clr) | m_set;
    end
  end

  // ---------------- monitor ----------------
  bit   prev_req = 0;
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_req = 0;
    else begin
      check("pending", bus.pending, m_pend);
      check("irq_req", bus.irq_req, m_state == REQ_S);
      check("in_service", bus.in_service, m_state == SVC_S);
      check("irq_src", bus.irq_src, (m_state != IDLE_S) ? (64'd1 << m_src) : 64'd0);
      if (m_state == REQ_S) check("irq_vec", bus.irq_vec, 32'h9 + 32'(m_src) * 32'h4);
      if (bus.irq_req && !prev_req) begin
        if (sbq.size() == 0) check("unexpected_req", 1, 0);
        else begin
          e = sbq.pop_front();
          check("req_cycle", cyc, e.cyc);
          check("req_src", bus.irq_src, 64'd1 << e.idx);
          check("req_vec", bus.irq_vec, 32'h9 + 32'(e.idx) * 32'h4);
        end
      end
      prev_req = bus.irq_req;
    end
  end

  // ---------------- stimulus ----------------
  logic [NUM_IO-1:0] io_v = '0;

  // hs: 0 = no handshake, 1 = prompt ack and rti, 2 = prompt ack only
  task automatic drv(bit le = 0, logic [1:0] sel = 0, logic [31:0] val = 0,
                     bit md = 0, bit ds = 0, int hs = 1);
    @(negedge clk);
    bus.ld_en = le; bus.ld_sel = sel; bus.ld_val = val; bus.ld_mode = md; bus.dis = ds;
    bus.io_irq = io_v;
    bus.int_ack = (hs != 0) && bus.irq_req;
    bus.rti = (hs == 1) && bus.in_service;
  endtask

  initial begin
    bus.ld_en = 0; bus.ld_sel = 0; bus.ld_val = 0; bus.ld_mode = 0; bus.dis = 0;
    bus.io_irq = 0; bus.int_ack = 0; bus.rti = 0;
    repeat (3) @(negedge clk);
    check("rst_req", bus.irq_req, 0);
    check("rst_vec", bus.irq_vec, 0);
    check("rst_src", bus.irq_src, 0);
    check("rst_insvc", bus.in_service, 0);
    check("rst_pend", bus.pending, 0);
    rst_n = 1;

    // one-shot ch0 = 5
    drv(1, 0, 5, 0);
    repeat (20) drv();
    // periodic ch1 = 3, then period 2 so ack-clear collides with a new expiry
    drv(1, 1, 3, 1);
    repeat (15) drv();
    drv(1, 1, 2, 1);
    repeat (10) drv();
    drv(0, 1, 0, 0, 1);
    repeat (6) drv();
    // ch2 and io0 pend on the same edge
    drv(1, 2, 4, 0);
    repeat (3) drv();
    io_v = 2'b01; drv();
    io_v = 2'b00; repeat (15) drv();
    // expiries and an io pulse while in service
    drv(1, 3, 1, 0, 0, 2);
    repeat (3) drv(0, 0, 0, 0, 0, 2);
    drv(1, 0, 2, 0, 0, 2);
    repeat (4) drv(0, 0, 0, 0, 0, 2);
    io_v = 2'b10; drv(0, 0, 0, 0, 0, 2);
    io_v = 2'b00; repeat (4) drv(0, 0, 0, 0, 0, 2);
    repeat (20) drv();
    // reload on the expiry edge, dis mid-countdown, dis on the expiry edge, ld+dis together
    drv(1, 1, 3, 0);
    repeat (2) drv();
    drv(1, 1, 6, 0);
    repeat (12) drv();
    drv(1, 2, 5, 0);
    repeat (2) drv();
    drv(0, 2, 0, 0, 1);
    repeat (8) drv();
    drv(1, 2, 3, 0);
    repeat (2) drv();
    drv(0, 2, 0, 0, 1);
    repeat (6) drv();
    drv(1, 3, 2, 0, 1);
    repeat (8) drv();
    drv(1, 0, 0, 0);
    repeat (10) drv();

    // four channels expire together, then async reset while requesting
    drv(1, 3, 6, 1, 0, 0);
    drv(1, 2, 5, 1, 0, 0);
    drv(1, 1, 4, 1, 0, 0);
    drv(1, 0, 3, 1, 0, 0);
    begin
      int k;
      k = 0;
      while (!(bus.irq_req && bus.pending[3:0] == 4'hF) && k < 20) begin
        drv(0, 0, 0, 0, 0, 0);
        k++;
      end
      check("t6_reach_req", k < 20, 1);
    end
    #2 rst_n = 0;
    #1;
    check("arst_req", bus.irq_req, 0);
    check("arst_vec", bus.irq_vec, 0);
    check("arst_src", bus.irq_src, 0);
    check("arst_insvc", bus.in_service, 0);
    check("arst_pend", bus.pending, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    repeat (3000) begin
      @(negedge clk);
      bus.ld_en = ($urandom % 12 == 0);
      bus.ld_sel = 2'($urandom);
      bus.ld_val = $urandom_range(0, 9);
      bus.ld_mode = 1'($urandom);
      bus.dis = ($urandom % 20 == 0);
      if ($urandom % 8 == 0) io_v = io_v ^ 2'($urandom);
      bus.io_irq = io_v;
      bus.int_ack = (bus.irq_req && ($urandom % 3 == 0)) || ($urandom % 20 == 0);
      bus.rti = (bus.in_service && ($urandom % 3 == 0)) || ($urandom % 20 == 0);
    end
    repeat (30) drv();
    check("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
